// File: rtl/execute_mul_iterative.sv
// ---------------------------------------------------------------------------
// execute_mul_iterative
//
// Purpose:
//   Iterative shift-add multiplier execute unit. It accepts one issued uop
//   from the D stage and returns the low p_data_bits of op1*op2 on the
//   W (writeback) channel. One multiplier bit is retired per CALC cycle, and
//   the operation finishes early once the remaining multiplier bits are all
//   zero. The latency from accept to W_val is (highest set bit of op2) + 2,
//   or 1 when op2 is zero. Only one uop is in flight at a time.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   D_val/D_rdy  issue handshake; D_rdy is high only while idle
//   D_pc         pc of the issued instruction
//   D_op1        multiplicand
//   D_op2        multiplier
//   D_waddr      destination register
//   D_seq_num    ROB tag
//   D_uop        issued uop; this unit only executes MUL, so it is ignored
//   W_val/W_rdy  writeback handshake; all W_* outputs hold while stalled
//   W_pc         pc passthrough
//   W_seq_num    ROB tag passthrough
//   W_waddr      destination passthrough
//   W_wdata      low half of the product
//   W_wen        register write enable, low when the destination is x0
// ---------------------------------------------------------------------------
module execute_mul_iterative #(
  parameter int p_addr_bits    = 32,
  parameter int p_data_bits    = 32,
  parameter int p_seq_num_bits = 5,
  // The rv_uop encoding belongs to decode; this unit only needs its width.
  parameter int p_uop_bits     = 8
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      D_val,
  output logic                      D_rdy,
  input  logic [p_addr_bits-1:0]    D_pc,
  input  logic [p_data_bits-1:0]    D_op1,
  input  logic [p_data_bits-1:0]    D_op2,
  input  logic [4:0]                D_waddr,
  input  logic [p_seq_num_bits-1:0] D_seq_num,
  input  logic [p_uop_bits-1:0]     D_uop,

  output logic                      W_val,
  input  logic                      W_rdy,
  output logic [p_addr_bits-1:0]    W_pc,
  output logic [p_seq_num_bits-1:0] W_seq_num,
  output logic [4:0]                W_waddr,
  output logic [p_data_bits-1:0]    W_wdata,
  output logic                      W_wen
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [p_data_bits-1:0]    a;
  logic [p_data_bits-1:0]    b;
  logic [p_data_bits-1:0]    acc;
  logic [p_data_bits-1:0]    b_shift;
  logic [p_addr_bits-1:0]    pc;
  logic [4:0]                waddr;
  logic [p_seq_num_bits-1:0] seq_num;

  logic accept;
  logic unused_uop;

  assign unused_uop = ^D_uop;

  assign b_shift = b >> 1;
  assign accept  = D_val && (state == IDLE);

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A zero multiplier skips CALC entirely, and CALC ends as
  // soon as the multiplier left after this cycle's shift is zero, which is
  // what gives the (highest set bit + 2) latency.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (D_val) begin
          state_next = (D_op2 == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (b_shift == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (W_rdy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and shift-add datapath. Everything the W channel needs is
  // captured at accept, so the D_* inputs are free to change afterwards, and
  // nothing moves in DONE, which keeps the W outputs stable under stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      a       <= '0;
      b       <= '0;
      acc     <= '0;
      pc      <= '0;
      waddr   <= '0;
      seq_num <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a       <= D_op1;
            b       <= D_op2;
            acc     <= '0;
            pc      <= D_pc;
            waddr   <= D_waddr;
            seq_num <= D_seq_num;
          end
        end
        CALC: begin
          if (b[0]) begin
            acc <= acc + a;
          end
          a <= a << 1;
          b <= b_shift;
        end
        default: begin
        end
      endcase
    end
  end

  assign D_rdy     = (state == IDLE);
  assign W_val     = (state == DONE);
  assign W_wdata   = acc;
  assign W_pc      = pc;
  assign W_seq_num = seq_num;
  assign W_waddr   = waddr;
  assign W_wen     = (waddr != 5'd0);

endmodule

// File: tb/tb_execute_mul_iterative.sv
// ---------------------------------------------------------------------------
// tb_execute_mul_iterative
//
// Purpose:
//   Self-checking bench for execute_mul_iterative. Expected products come
//   from plain 64-bit arithmetic and expected latencies from the position of
//   the highest set multiplier bit; each comparison is an immediate assertion.
// ---------------------------------------------------------------------------
module tb_execute_mul_iterative;

  logic        clk;
  logic        rst;
  logic        D_val;
  logic        D_rdy;
  logic [31:0] D_pc;
  logic [31:0] D_op1;
  logic [31:0] D_op2;
  logic [4:0]  D_waddr;
  logic [4:0]  D_seq_num;
  logic [7:0]  D_uop;
  logic        W_val;
  logic        W_rdy;
  logic [31:0] W_pc;
  logic [4:0]  W_seq_num;
  logic [4:0]  W_waddr;
  logic [31:0] W_wdata;
  logic        W_wen;

  int checks;
  int fails;

  execute_mul_iterative dut (
    .clk       (clk),
    .rst       (rst),
    .D_val     (D_val),
    .D_rdy     (D_rdy),
    .D_pc      (D_pc),
    .D_op1     (D_op1),
    .D_op2     (D_op2),
    .D_waddr   (D_waddr),
    .D_seq_num (D_seq_num),
    .D_uop     (D_uop),
    .W_val     (W_val),
    .W_rdy     (W_rdy),
    .W_pc      (W_pc),
    .W_seq_num (W_seq_num),
    .W_waddr   (W_waddr),
    .W_wdata   (W_wdata),
    .W_wen     (W_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: product is the low 32 bits of the full 64-bit product.
  function automatic logic [31:0] model_product(input logic [31:0] x,
                                                input logic [31:0] y);
    logic [63:0] full;
    full = {32'd0, x} * {32'd0, y};
    return full[31:0];
  endfunction

  // Reference model: 1 cycle for a zero multiplier, else highest set bit + 2.
  function automatic int model_latency(input logic [31:0] y);
    int k;
    k = -1;
    for (int i = 0; i < 32; i++) begin
      if (y[i]) k = i;
    end
    return (k < 0) ? 1 : k + 2;
  endfunction

  // Issues one op, checks latency and the writeback fields, optionally stalls
  // W_rdy for 'stall' cycles. With hold_dval set, a follow-up issue (7*9)
  // is presented on D during the stall to show it is not taken early.
  task automatic apply_stimulus(input logic [31:0] op1, input logic [31:0] op2,
                                input logic [4:0] waddr, input logic [4:0] seq,
                                input logic [31:0] pc, input int stall,
                                input int gap, input bit hold_dval);
    logic [31:0] exp_prod;
    int          exp_lat;
    int          lat;
    int          wait_cnt;
    exp_prod = model_product(op1, op2);
    exp_lat  = model_latency(op2);
    W_rdy    = 1'b1;
    repeat (gap) step();
    wait_cnt = 0;
    while (!D_rdy && wait_cnt < 50) begin
      step();
      wait_cnt++;
    end
    check_output("issue_rdy", D_rdy, 1);
    D_val     = 1'b1;
    D_op1     = op1;
    D_op2     = op2;
    D_waddr   = waddr;
    D_seq_num = seq;
    D_pc      = pc;
    step();
    D_val = 1'b0;
    D_op1 = $urandom;
    D_op2 = $urandom;
    lat = 1;
    while (!W_val && lat < 40) begin
      check_output("busy_rdy", D_rdy, 0);
      step();
      lat++;
    end
    check_output("latency", lat, exp_lat);
    check_output("wdata", W_wdata, exp_prod);
    check_output("waddr", W_waddr, waddr);
    check_output("wen", W_wen, (waddr != 5'd0));
    check_output("seq", W_seq_num, seq);
    check_output("pc", W_pc, pc);
    if (stall > 0) begin
      W_rdy = 1'b0;
      if (hold_dval) begin
        D_val     = 1'b1;
        D_op1     = 32'd7;
        D_op2     = 32'd9;
        D_waddr   = 5'd3;
        D_seq_num = 5'd6;
        D_pc      = 32'h40;
      end
      for (int s = 0; s < stall; s++) begin
        step();
        check_output("stall_val", W_val, 1);
        check_output("stall_wdata", W_wdata, exp_prod);
        check_output("stall_seq", W_seq_num, seq);
        check_output("stall_rdy", D_rdy, 0);
      end
      W_rdy = 1'b1;
    end
    step();
    check_output("post_hs_val", W_val, 0);
    check_output("post_hs_rdy", D_rdy, 1);
  endtask

  initial begin
    logic [31:0] r1;
    logic [31:0] r2;
    bit          saw_val;
    checks    = 0;
    fails     = 0;
    rst       = 1'b1;
    D_val     = 1'b0;
    D_pc      = '0;
    D_op1     = '0;
    D_op2     = '0;
    D_waddr   = '0;
    D_seq_num = '0;
    D_uop     = 8'h5a;
    W_rdy     = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // Reset state.
    check_output("rst_rdy", D_rdy, 1);
    check_output("rst_val", W_val, 0);
    check_output("rst_wdata", W_wdata, 0);
    check_output("rst_waddr", W_waddr, 0);
    check_output("rst_pc", W_pc, 0);
    check_output("rst_seq", W_seq_num, 0);
    check_output("rst_wen", W_wen, 0);

    // Basic op, zero and one multipliers, wrap and maximum latency.
    apply_stimulus(32'd3, 32'd7, 5'd4, 5'd2, 32'h0, 0, 0, 1'b0);
    apply_stimulus(32'h1234, 32'd0, 5'd5, 5'd1, 32'h4, 0, 0, 1'b0);
    apply_stimulus(32'd10, 32'd1, 5'd6, 5'd3, 32'h8, 0, 1, 1'b0);
    apply_stimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 5'd4, 32'hC, 0, 0, 1'b0);
    apply_stimulus(32'h80000000, 32'd2, 5'd8, 5'd5, 32'h10, 0, 0, 1'b0);

    // Backpressure with x0 destination, D_val held for the next op.
    apply_stimulus(32'd6, 32'd5, 5'd0, 5'd9, 32'h20, 5, 0, 1'b1);
    apply_stimulus(32'd7, 32'd9, 5'd3, 5'd6, 32'h40, 0, 0, 1'b0);

    // Reset in the middle of CALC drops the op.
    D_val     = 1'b1;
    D_op1     = 32'd5;
    D_op2     = 32'h80000000;
    D_waddr   = 5'd2;
    D_seq_num = 5'd7;
    D_pc      = 32'h80;
    step();
    D_val = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_output("midrst_rdy", D_rdy, 1);
    check_output("midrst_val", W_val, 0);
    saw_val = 1'b0;
    for (int c = 0; c < 35; c++) begin
      if (W_val) saw_val = 1'b1;
      step();
    end
    check_output("dropped_op", saw_val, 0);
    apply_stimulus(32'd2, 32'd3, 5'd1, 5'd8, 32'h84, 0, 0, 1'b0);

    // Random back-to-back stream with random stalls and issue gaps.
    for (int n = 0; n < 4; n++) begin
      r1 = $urandom;
      r2 = $urandom;
      if (n == 1) r2 = r2 >> $urandom_range(31, 20);
      apply_stimulus(r1, r2, 5'($urandom_range(31, 0)), 5'(n + 10),
                     32'h100 + 32'(n * 4), $urandom_range(3, 0),
                     $urandom_range(2, 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/execute_mul_iterative.md
Name: execute_mul_iterative

Overview:
Iterative shift-add multiplier execute unit. It sits directly downstream of the decode/issue stage on one D__X pipe whose op subset is OP_MUL_VEC. It consumes one issued uop (op1, op2, waddr, seq_num, pc) and produces the low 32 bits of the product on a val/rdy writeback (X__W) channel. Latency is variable, with early termination when the remaining multiplier bits are zero.

Parameters:
p_addr_bits, 32, width of pc
p_data_bits, 32, operand/result width
p_seq_num_bits, 5, ROB sequence-number width (clog2 of ROB entries)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
D_val  input  1  issue valid
D_rdy  output  1  unit can accept an issue
D_pc  input  p_addr_bits  pc of issued inst
D_op1  input  p_data_bits  multiplicand
D_op2  input  p_data_bits  multiplier
D_waddr  input  5  destination register
D_seq_num  input  p_seq_num_bits  ROB tag
D_uop  input  rv_uop  issued uop, ignored (always treated as OP_MUL)
W_val  output  1  result valid
W_rdy  input  1  writeback ready
W_pc  output  p_addr_bits  pc passthrough
W_seq_num  output  p_seq_num_bits  tag passthrough
W_waddr  output  5  destination passthrough
W_wdata  output  p_data_bits  product[p_data_bits-1:0]
W_wen  output  1  1 iff waddr != 0

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- FSM states: IDLE, CALC, DONE. Reset -> IDLE. Reset values: D_rdy=1 (IDLE), W_val=0; W_wdata/W_waddr/W_pc/W_seq_num/W_wen = 0.
- D_rdy = (state==IDLE), combinational from state only. D_rdy does not depend on D_val.
- Accept on posedge with D_val && D_rdy:
  - Latch a=op1, b=op2, acc=0, pc, waddr, seq_num.
  - If op2==0, go to DONE; else go to CALC.
- CALC, each cycle:
  - If b[0], acc += a (mod 2^p_data_bits).
  - a <<= 1 (bits shifted out are lost); b >>= 1 (logical).
  - If the updated b==0, go to DONE.
- Latency from the accept edge to the first cycle with W_val=1 is k+2 cycles, where k is the index of the highest set bit of op2. If op2==0, latency is 1 cycle. Maximum latency is p_data_bits+1.
- DONE:
  - W_val=1, W_wdata=acc.
  - All W_* outputs hold stable while W_val && !W_rdy, for any stall length.
  - On W_val && W_rdy, go to IDLE. No new accept that same edge, so the minimum issue-to-issue interval is latency+1.
- Only one uop is in flight; there is no internal buffering.
- W_wen=0 when waddr==0; wdata is still the computed product.
- Signedness is irrelevant: the low-half product is identical for signed and unsigned operands.
- Operand values are captured at accept; D_op* may change afterwards without effect.
- rst asserted in any state (mid-CALC, or DONE with W_rdy low) returns to IDLE next edge: the in-flight op is dropped, W_val=0, and no W handshake occurs. rst overrides a same-edge accept or W handshake.
- D_val while not in IDLE is ignored (D_rdy=0). The upstream stage holds its message.

Test Plan:
- Reset, then issue op1=3 op2=7 waddr=4 seq=2 pc=0x0 with W_rdy=1 -> D_rdy=0 during compute; W_val rises 4 cycles after accept (k=2) with wdata=21 waddr=4 wen=1 seq=2 pc=0x0; D_rdy=1 the cycle after the handshake.
- Zero and one multiplier: op2=0 with op1=0x1234 -> W_val 1 cycle after accept, wdata=0. Then op1=10 op2=1 -> W_val after 2 cycles, wdata=10.
- Wrap and maximum latency: op1=0xFFFFFFFF op2=0xFFFFFFFF -> W_val after 33 cycles, wdata=0x00000001. Then op1=0x80000000 op2=2 -> wdata=0.
- Backpressure: op1=6 op2=5 waddr=0 with W_rdy=0 for 5 cycles once W_val=1 -> W_val and outputs held (wdata=30, wen=0); the handshake completes on the first W_rdy=1 edge; a D_val asserted throughout is accepted only the cycle after.
- Reset mid-operation: accept op2=0x80000000, assert rst for one cycle at CALC cycle 10 -> next cycle IDLE, D_rdy=1, W_val=0 and never rises for the dropped op. A following op1=2 op2=3 yields wdata=6.
- Back-to-back stream: 4 random op pairs with random W_rdy and D_val gaps -> results in issue order, each equal to (op1*op2) mod 2^32 with correct seq_num/pc/waddr; no loss or duplication.
